// File: rtl/hazard_unit.sv
// hazard_unit: load-use, branch-flush and memory-freeze sequencing for the five-stage MIPS pipeline
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   idValid/idRs/idRt/idUsesRt  instruction currently in ID
//   exMemRead/exRt            load at the ID/EX output
//   memBranch/memZero         branch resolution in MEM
//   dmemReq/dmemReady         data-memory handshake in MEM
//   pcWrite..pipeHold         Mealy pipeline-register controls
//   stallCount/flushCount     saturating event statistics
//   memError                  sticky memory-timeout flag
module hazard_unit #(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        idValid,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idUsesRt,
    input  logic        exMemRead,
    input  logic [4:0]  exRt,
    input  logic        memBranch,
    input  logic        memZero,
    input  logic        dmemReq,
    input  logic        dmemReady,
    output logic        pcWrite,
    output logic        pcSelBranch,
    output logic        ifIdWrite,
    output logic        ifIdFlush,
    output logic        idExFlush,
    output logic        exMemFlush,
    output logic        pipeHold,
    output logic [15:0] stallCount,
    output logic [15:0] flushCount,
    output logic        memError
);
    localparam logic [1:0]  RUN          = 2'd0;
    localparam logic [1:0]  STALL        = 2'd1;
    localparam logic [1:0]  WAIT         = 2'd2;
    localparam logic [3:0]  LU_RELOAD    = 4'(LU_STALL_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);
    logic [1:0]  state, nextState;
    logic [3:0]  luCnt, nextLuCnt;
    logic [15:0] waitCnt;
    logic        retStall;
    logic        branchTaken, memWait, loadUse, effStall;
    logic        doFreeze, doBranch, doBubble;
    assign branchTaken = memBranch & memZero;
    assign memWait     = dmemReq & ~dmemReady;
    assign loadUse     = idValid & exMemRead & (exRt != 5'd0) &
                         ((exRt == idRs) | (idUsesRt & (exRt == idRt)));
    // Leaving WAIT, the cycle behaves as the state that was frozen.
    assign effStall    = (state == STALL) | ((state == WAIT) & retStall);
    // Gating with reset_n forces the reset-time control values even while reset is held.
    assign doFreeze    = reset_n & memWait;
    assign doBranch    = reset_n & ~memWait & branchTaken;
    assign doBubble    = reset_n & ~memWait & ~branchTaken & (effStall | loadUse);
    assign pcWrite     = ~doFreeze & ~doBubble;
    assign ifIdWrite   = ~doFreeze & ~doBubble;
    assign pcSelBranch = doBranch;
    assign ifIdFlush   = doBranch;
    assign exMemFlush  = doBranch;
    assign idExFlush   = doBranch | doBubble;
    assign pipeHold    = doFreeze;
    always_comb begin
        nextState = RUN;
        nextLuCnt = luCnt;
        if (memWait) begin
            nextState = WAIT;
        end else if (branchTaken) begin
            nextLuCnt = 4'd0;
        end else if (effStall) begin
            nextLuCnt = luCnt - 4'd1;
            nextState = (luCnt == 4'd1) ? RUN : STALL;
        end else if (loadUse && LU_STALL_CYCLES > 1) begin
            nextState = STALL;
            nextLuCnt = LU_RELOAD;
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            luCnt      <= 4'd0;
            waitCnt    <= 16'd0;
            retStall   <= 1'b0;
            stallCount <= 16'd0;
            flushCount <= 16'd0;
            memError   <= 1'b0;
        end else begin
            state   <= nextState;
            luCnt   <= nextLuCnt;
            waitCnt <= memWait ? ((waitCnt == 16'hFFFF) ? waitCnt : waitCnt + 16'd1) : 16'd0;
            if (memWait && state != WAIT)
                retStall <= (state == STALL);
            // waitCnt counts prior frozen cycles, so this is the MEM_TIMEOUT-th one.
            if (memWait && waitCnt == TIMEOUT_LAST)
                memError <= 1'b1;
            if (doBranch && flushCount != 16'hFFFF)
                flushCount <= flushCount + 16'd1;
            if (doBubble && stallCount != 16'hFFFF)
                stallCount <= stallCount + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a bubble/wait-run model
module tb_hazard_unit;
    localparam logic [6:0] DEF = 7'b1010000;
    localparam logic [6:0] FRZ = 7'b0000001;
    localparam logic [6:0] BRN = 7'b1111110;
    localparam logic [6:0] BUB = 7'b0000100;
    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic idValid, idUsesRt, exMemRead, memBranch, memZero, dmemReq, dmemReady;
    logic [4:0] idRs, idRt, exRt;
    logic [1:0] pcWrite, pcSelBranch, ifIdWrite, ifIdFlush, idExFlush, exMemFlush, pipeHold, memError;
    logic [15:0] stallCount [2];
    logic [15:0] flushCount [2];
    logic [6:0] act [2];
    int checks = 0;
    int errors = 0;
    int m_bub [2];
    int m_wlen [2];
    int m_sc [2];
    int m_fc [2];
    logic m_err [2];
    always #5 clock = ~clock;
    hazard_unit #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(4)) dut1 (
        .clock(clock), .reset_n(reset_n), .idValid(idValid), .idRs(idRs), .idRt(idRt),
        .idUsesRt(idUsesRt), .exMemRead(exMemRead), .exRt(exRt), .memBranch(memBranch),
        .memZero(memZero), .dmemReq(dmemReq), .dmemReady(dmemReady), .pcWrite(pcWrite[0]),
        .pcSelBranch(pcSelBranch[0]), .ifIdWrite(ifIdWrite[0]), .ifIdFlush(ifIdFlush[0]),
        .idExFlush(idExFlush[0]), .exMemFlush(exMemFlush[0]), .pipeHold(pipeHold[0]),
        .stallCount(stallCount[0]), .flushCount(flushCount[0]), .memError(memError[0]));
    hazard_unit #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(255)) dut3 (
        .clock(clock), .reset_n(reset_n), .idValid(idValid), .idRs(idRs), .idRt(idRt),
        .idUsesRt(idUsesRt), .exMemRead(exMemRead), .exRt(exRt), .memBranch(memBranch),
        .memZero(memZero), .dmemReq(dmemReq), .dmemReady(dmemReady), .pcWrite(pcWrite[1]),
        .pcSelBranch(pcSelBranch[1]), .ifIdWrite(ifIdWrite[1]), .ifIdFlush(ifIdFlush[1]),
        .idExFlush(idExFlush[1]), .exMemFlush(exMemFlush[1]), .pipeHold(pipeHold[1]),
        .stallCount(stallCount[1]), .flushCount(flushCount[1]), .memError(memError[1]));
    assign act[0] = {pcWrite[0], pcSelBranch[0], ifIdWrite[0], ifIdFlush[0], idExFlush[0], exMemFlush[0], pipeHold[0]};
    assign act[1] = {pcWrite[1], pcSelBranch[1], ifIdWrite[1], ifIdFlush[1], idExFlush[1], exMemFlush[1], pipeHold[1]};
    function automatic logic lu_now();
        return idValid && exMemRead && exRt != 5'd0 && (exRt == idRs || (idUsesRt && exRt == idRt));
    endfunction
    function automatic logic [6:0] exp_ctl(int i);
        if (!reset_n) return DEF;
        if (dmemReq && !dmemReady) return FRZ;
        if (memBranch && memZero) return BRN;
        if (m_bub[i] > 0 || lu_now()) return BUB;
        return DEF;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_bub[i] = 0; m_wlen[i] = 0; m_sc[i] = 0; m_fc[i] = 0; m_err[i] = 1'b0;
        end
    endtask
    task automatic tick();
        for (int i = 0; i < 2; i++) begin
            if (dmemReq && !dmemReady) begin
                m_wlen[i]++;
                if (m_wlen[i] >= (i == 0 ? 4 : 255)) m_err[i] = 1'b1;
            end else begin
                m_wlen[i] = 0;
                if (memBranch && memZero) begin
                    m_bub[i] = 0;
                    if (m_fc[i] < 65535) m_fc[i]++;
                end else if (m_bub[i] > 0 || lu_now()) begin
                    m_bub[i] = (m_bub[i] > 0) ? m_bub[i] - 1 : (i == 0 ? 0 : 2);
                    if (m_sc[i] < 65535) m_sc[i]++;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask
    task automatic idle();
        idValid = 0; idRs = 0; idRt = 0; idUsesRt = 0; exMemRead = 0; exRt = 0;
        memBranch = 0; memZero = 0; dmemReq = 0; dmemReady = 1;
    endtask
    task automatic set_lu();
        idValid = 1; exMemRead = 1; exRt = 5'd8; idRs = 5'd8;
    endtask
    task automatic do_reset();
        reset_n = 0;
        #1;
        idle();
        model_reset();
        @(negedge clock);
        reset_n = 1;
        tick();
    endtask
    task automatic test_reset();
        #1 reset_n = 0;
        idle();
        set_lu();
        dmemReq = 1; dmemReady = 0; memBranch = 1; memZero = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act[i] !== DEF || stallCount[i] !== 16'd0 || flushCount[i] !== 16'd0 || memError[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d ctl %b want %b sc %h fc %h err %b", i, act[i], DEF, stallCount[i], flushCount[i], memError[i]);
            end
        end
        do_reset();
    endtask
    task automatic test_loaduse_lu1();
        do_reset();
        set_lu();
        #1;
        checks++;
        if (act[0] !== BUB) begin errors++; $display("FAIL lu1_bubble got %b want %b", act[0], BUB); end
        tick();
        idle();
        #1;
        checks++;
        if (act[0] !== DEF) begin errors++; $display("FAIL lu1_release got %b want %b", act[0], DEF); end
        checks++;
        if (stallCount[0] !== 16'd1) begin errors++; $display("FAIL lu1_count got %0d want 1", stallCount[0]); end
    endtask
    task automatic test_no_stall();
        do_reset();
        idValid = 1; exMemRead = 1; exRt = 0; idRs = 0; idRt = 0; idUsesRt = 1;
        #1;
        checks++;
        if (act[0] !== DEF || act[1] !== DEF) begin errors++; $display("FAIL rt0_nostall got %b %b want %b", act[0], act[1], DEF); end
        tick();
        exRt = 5'd5; idRt = 5'd5; idRs = 5'd1; idUsesRt = 0;
        #1;
        checks++;
        if (act[0] !== DEF || act[1] !== DEF) begin errors++; $display("FAIL rt_unused got %b %b want %b", act[0], act[1], DEF); end
        tick();
        checks++;
        if (stallCount[0] !== 16'd0 || stallCount[1] !== 16'd0) begin errors++; $display("FAIL nostall_count got %0d %0d want 0", stallCount[0], stallCount[1]); end
        idUsesRt = 1;
        #1;
        checks++;
        if (act[1] !== BUB) begin errors++; $display("FAIL rt_used got %b want %b", act[1], BUB); end
        tick();
        idle();
    endtask
    task automatic test_stall_wait();
        logic [6:0] want [6];
        want = '{BUB, FRZ, FRZ, BUB, BUB, DEF};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            idle();
            if (k == 0) set_lu();
            if (k == 1 || k == 2) begin dmemReq = 1; dmemReady = 0; end
            #1;
            checks++;
            if (act[1] !== want[k]) begin errors++; $display("FAIL stall_wait cyc%0d got %b want %b", k, act[1], want[k]); end
            tick();
        end
        checks++;
        if (stallCount[1] !== 16'd3) begin errors++; $display("FAIL stall_wait_count got %0d want 3", stallCount[1]); end
    endtask
    task automatic test_branch_vs_loaduse();
        do_reset();
        set_lu();
        memBranch = 1; memZero = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act[i] !== BRN) begin errors++; $display("FAIL branch dut%0d got %b want %b", i, act[i], BRN); end
        end
        tick();
        idle();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act[i] !== DEF || flushCount[i] !== 16'd1 || stallCount[i] !== 16'd0) begin
                errors++;
                $display("FAIL branch_after dut%0d ctl %b fc %0d sc %0d want %b 1 0", i, act[i], flushCount[i], stallCount[i], DEF);
            end
        end
    endtask
    task automatic test_timeout();
        do_reset();
        dmemReq = 1; dmemReady = 0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            checks++;
            if (pipeHold[0] !== 1'b1 || memError[0] !== (k > 4)) begin
                errors++;
                $display("FAIL timeout cyc%0d hold %b err %b want 1 %b", k, pipeHold[0], memError[0], k > 4);
            end
            tick();
        end
        dmemReady = 1;
        #1;
        checks++;
        if (act[0] !== DEF || memError[0] !== 1'b1) begin errors++; $display("FAIL timeout_ready ctl %b err %b want %b 1", act[0], memError[0], DEF); end
        tick();
        idle();
        tick();
        checks++;
        if (memError[0] !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", memError[0]); end
        reset_n = 0;
        #1;
        checks++;
        if (memError[0] !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", memError[0]); end
        do_reset();
    endtask
    task automatic test_random();
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            idValid = $urandom_range(0, 3) != 0;
            idRs = 5'($urandom_range(0, 3));
            idRt = 5'($urandom_range(0, 3));
            exRt = 5'($urandom_range(0, 3));
            idUsesRt = 1'($urandom_range(0, 1));
            exMemRead = 1'($urandom_range(0, 1));
            memBranch = $urandom_range(0, 7) == 0;
            memZero = 1'($urandom_range(0, 1));
            dmemReq = $urandom_range(0, 2) == 0;
            dmemReady = 1'($urandom_range(0, 1));
            #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act[i] !== exp_ctl(i) || stallCount[i] !== 16'(m_sc[i]) || flushCount[i] !== 16'(m_fc[i]) || memError[i] !== m_err[i]) begin
                    errors++;
                    $display("FAIL random n%0d dut%0d ctl %b sc %0d fc %0d err %b want %b %0d %0d %b",
                             n, i, act[i], stallCount[i], flushCount[i], memError[i], exp_ctl(i), m_sc[i], m_fc[i], m_err[i]);
                end
            end
            tick();
        end
        idle();
    endtask
    task automatic test_saturation();
        do_reset();
        set_lu();
        repeat (65534) tick();
        checks++;
        if (stallCount[0] !== 16'hFFFE) begin errors++; $display("FAIL sat_preset got %h want fffe", stallCount[0]); end
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (stallCount[i] !== 16'hFFFF) begin errors++; $display("FAIL sat_nowrap dut%0d got %h want ffff", i, stallCount[i]); end
        end
    endtask
    task automatic test_reset_mid_stall();
        idle();
        repeat (3) tick();
        set_lu();
        tick();
        idle();
        #1;
        checks++;
        if (act[1] !== BUB) begin errors++; $display("FAIL mid_stall_pre got %b want %b", act[1], BUB); end
        #2 reset_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act[i] !== DEF || stallCount[i] !== 16'd0 || flushCount[i] !== 16'd0 || memError[i] !== 1'b0) begin
                errors++;
                $display("FAIL mid_stall_reset dut%0d ctl %b sc %h fc %h err %b want %b 0 0 0", i, act[i], stallCount[i], flushCount[i], memError[i], DEF);
            end
        end
        do_reset();
        #1;
        checks++;
        if (act[1] !== DEF) begin errors++; $display("FAIL mid_stall_run got %b want %b", act[1], DEF); end
    endtask
    initial begin
        test_reset();
        test_loaduse_lu1();
        test_no_stall();
        test_stall_wait();
        test_branch_vs_loaduse();
        test_timeout();
        test_random();
        test_saturation();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
